// File: rtl/act_pkg.sv
// Shared defaults and derived-width helpers for the piecewise-linear activation pipeline.
package act_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_N_FUNC = 2;

  function automatic int frac_w(input int data_w, input int addr_w);
    return data_w - addr_w;
  endfunction

  // A single table still needs a one-bit select port.
  function automatic int fsel_w(input int n_func);
    return (n_func <= 2) ? 1 : $clog2(n_func);
  endfunction

endpackage

// File: rtl/act_lut_rf.sv
// Activation table register file: one write port, two combinational reads
// returning the segment base and its right-hand neighbour.
module act_lut_rf import act_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_FUNC = DEF_N_FUNC,
  localparam int FSEL_W = fsel_w(N_FUNC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [FSEL_W-1:0]        wr_func,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [FSEL_W-1:0]        rd_func,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_base,
  output logic signed [DATA_W-1:0] rd_next
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_POS = {1'b0, {(ADDR_W-1){1'b1}}};

  logic signed [DATA_W-1:0] mem [N_FUNC][DEPTH];
  logic [FSEL_W-1:0]        sel;
  logic [ADDR_W-1:0]        next_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < N_FUNC; f++)
        for (int a = 0; a < DEPTH; a++)
          mem[f][a] <= '0;
    end else if (wr_en && (int'(wr_func) < N_FUNC)) begin
      mem[wr_func][wr_addr] <= wr_data;
    end
  end

  // Out-of-range selects fall back to table 0; the most positive segment is
  // flat so large inputs never interpolate toward the negative wrap entry.
  always_comb begin
    sel       = (int'(rd_func) < N_FUNC) ? rd_func : '0;
    next_addr = (rd_addr == TOP_POS) ? rd_addr : rd_addr + 1'b1;
    rd_base   = mem[sel][rd_addr];
    rd_next   = mem[sel][next_addr];
  end

endmodule

// File: rtl/act_interp_pipe.sv
// Three-stage elastic piecewise-linear activation: S1 table lookup,
// S2 slope multiply, S3 base add. One sample per cycle when unstalled.
module act_interp_pipe import act_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_FUNC = DEF_N_FUNC,
  localparam int FRAC_W = frac_w(DATA_W, ADDR_W),
  localparam int FSEL_W = fsel_w(N_FUNC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_z,
  input  logic [FSEL_W-1:0]        in_func,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_a,
  input  logic                     cfg_we,
  input  logic [FSEL_W-1:0]        cfg_func,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic signed [DATA_W-1:0] cfg_data
);

  localparam int PW = DATA_W + FRAC_W + 2;

  if (ADDR_W < 2 || FRAC_W < 1) begin : g_bad_params
    $error("act_interp_pipe: need ADDR_W >= 2 and DATA_W - ADDR_W >= 1");
  end

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; a producer holding valid keeps its data stable until then.
  logic                     s1_v, s2_v, s3_v;
  logic                     ld1, ld2, ld3;
  logic signed [DATA_W-1:0] lut_base, lut_next;
  logic signed [DATA_W-1:0] s1_base, s1_next, s2_base, s3_a;
  logic [FRAC_W-1:0]        s1_rem;
  logic signed [DATA_W:0]   s1_diff;
  logic signed [PW-1:0]     s1_prod, s2_prod;

  act_lut_rf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .N_FUNC (N_FUNC)
  ) u_lut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_we),
    .wr_func (cfg_func),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_func (in_func),
    .rd_addr (in_z[DATA_W-1 -: ADDR_W]),
    .rd_base (lut_base),
    .rd_next (lut_next)
  );

  // A stage may load when it is empty or its contents are leaving this edge.
  assign ld3      = !s3_v || out_ready;
  assign ld2      = !s2_v || ld3;
  assign ld1      = !s1_v || ld2;
  assign in_ready = ld1;

  assign out_valid = s3_v;
  assign out_a     = s3_a;

  assign s1_diff = (DATA_W+1)'(s1_next) - (DATA_W+1)'(s1_base);
  assign s1_prod = PW'(s1_diff) * PW'($signed({1'b0, s1_rem}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      s1_base <= '0;
      s1_next <= '0;
      s1_rem  <= '0;
      s2_base <= '0;
      s2_prod <= '0;
      s3_a    <= '0;
    end else begin
      if (ld1) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_base <= lut_base;
          s1_next <= lut_next;
          s1_rem  <= in_z[FRAC_W-1:0];
        end
      end
      if (ld2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_base <= s1_base;
          s2_prod <= s1_prod;
        end
      end
      if (ld3) begin
        s3_v <= s2_v;
        if (s2_v) s3_a <= DATA_W'(s2_base + (s2_prod >>> FRAC_W));
      end
    end
  end

endmodule
